// File: rtl/cache_mem_ctrl.sv
// Memory-side stage behind sa_cache: buffers eviction writebacks in a small FIFO and
// serialises writebacks and line fills onto one req/ack memory port, writebacks first.
module cache_mem_ctrl #(
  parameter int WB_DEPTH = 2,
  parameter int TIMEOUT  = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_miss,
  input  logic [31:0] i_miss_addr,
  input  logic        i_evict,
  input  logic [31:0] i_evict_addr,
  input  logic [31:0] i_evict_data,
  output logic [31:0] o_memory_line,
  output logic        o_memory_response,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic        o_wb_full,
  output logic        o_err
);

  localparam int PW = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(WB_DEPTH);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, WB_REQ, RD_REQ, RESP, GAP} state_e;

  // Memory handshake: o_mem_req/o_mem_we/o_mem_addr/o_mem_wdata are valid while o_mem_req
  // is high and stay stable until i_mem_ack is sampled high; acks while o_mem_req is low are ignored.
  logic [25:0]   fifo_line [WB_DEPTH];
  logic [31:0]   fifo_data [WB_DEPTH];

  state_e        state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pending_q, pending_d;
  logic [25:0]   miss_line_q, miss_line_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   line_q, line_d;
  logic          resp_q, resp_d;
  logic          err_q, err_d;
  logic          push, pop;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^{i_miss_addr[5:0], i_evict_addr[5:0]};

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    pending_d   = pending_q;
    miss_line_d = miss_line_q;
    tmo_d       = tmo_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    line_d      = line_q;
    resp_d      = 1'b0;
    err_d       = err_q;
    pop         = 1'b0;
    push        = i_evict && (count_q != FULL_CNT);

    if (i_evict && !push) err_d = 1'b1;

    // The cache holds i_miss until it has seen the response, so the clear wins over a recapture.
    if (resp_q) begin
      pending_d = 1'b0;
    end else if (i_miss && !pending_q) begin
      pending_d   = 1'b1;
      miss_line_d = i_miss_addr[31:6];
    end

    case (state_q)
      IDLE: begin
        if (count_q != '0)  state_d = WB_REQ;
        else if (pending_q) state_d = RD_REQ;
      end
      WB_REQ, RD_REQ: begin
        if (!req_q) begin
          req_d = 1'b1;
          if (state_q == WB_REQ) begin
            we_d    = 1'b1;
            addr_d  = {fifo_line[rd_ptr_q], 6'd0};
            wdata_d = fifo_data[rd_ptr_q];
          end else begin
            we_d    = 1'b0;
            addr_d  = {miss_line_q, 6'd0};
            wdata_d = '0;
          end
        end else if (i_mem_ack) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          addr_d  = '0;
          wdata_d = '0;
          tmo_d   = '0;
          if (state_q == WB_REQ) begin
            pop     = 1'b1;
            state_d = GAP;
          end else begin
            line_d  = i_mem_rdata;
            state_d = RESP;
          end
        end else if (tmo_q == TO_LAST) begin
          // Give up on this attempt; IDLE reissues from the unchanged FIFO/pending state.
          err_d   = 1'b1;
          req_d   = 1'b0;
          we_d    = 1'b0;
          addr_d  = '0;
          wdata_d = '0;
          tmo_d   = '0;
          state_d = GAP;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      RESP: begin
        resp_d  = 1'b1;
        state_d = GAP;
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      pending_q   <= 1'b0;
      miss_line_q <= '0;
      tmo_q       <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      line_q      <= '0;
      resp_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      pending_q   <= pending_d;
      miss_line_q <= miss_line_d;
      tmo_q       <= tmo_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      line_q      <= line_d;
      resp_q      <= resp_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && push) begin
      fifo_line[wr_ptr_q] <= i_evict_addr[31:6];
      fifo_data[wr_ptr_q] <= i_evict_data;
    end
  end

  assign o_memory_line     = line_q;
  assign o_memory_response = resp_q;
  assign o_mem_req         = req_q;
  assign o_mem_we          = we_q;
  assign o_mem_addr        = addr_q;
  assign o_mem_wdata       = wdata_q;
  assign o_wb_full         = (count_q == FULL_CNT);
  assign o_err             = err_q;

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Bench for cache_mem_ctrl: directed scenarios plus random writeback/fill episodes, all
// checked against a transaction-level model (writeback queue, pending miss, timeout run).
module tb_cache_mem_ctrl;

  localparam int WB_DEPTH = 2;
  localparam int TIMEOUT  = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_miss;
  logic [31:0] i_miss_addr;
  logic        i_evict;
  logic [31:0] i_evict_addr;
  logic [31:0] i_evict_data;
  logic [31:0] o_memory_line;
  logic        o_memory_response;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;
  logic        o_wb_full;
  logic        o_err;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [63:0] exp_q[$];
  logic [31:0] exp_line = '0;
  bit          resp_due = 0;
  bit          model_pending = 0;
  logic [31:0] model_miss_addr = '0;
  bit          model_err = 0;
  int          wait_run = 0;
  int          n_wr = 0;
  int          n_rd = 0;

  bit          auto_ack = 0;
  int          ack_delay = 0;
  int          ack_wait = 0;

  cache_mem_ctrl #(.WB_DEPTH(WB_DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk               (clk),
    .rst               (rst),
    .i_miss            (i_miss),
    .i_miss_addr       (i_miss_addr),
    .i_evict           (i_evict),
    .i_evict_addr      (i_evict_addr),
    .i_evict_data      (i_evict_data),
    .o_memory_line     (o_memory_line),
    .o_memory_response (o_memory_response),
    .o_mem_req         (o_mem_req),
    .o_mem_we          (o_mem_we),
    .o_mem_addr        (o_mem_addr),
    .o_mem_wdata       (o_mem_wdata),
    .i_mem_ack         (i_mem_ack),
    .i_mem_rdata       (i_mem_rdata),
    .o_wb_full         (o_wb_full),
    .o_err             (o_err)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: optional auto-responder, pre-edge checks, model update at the edge,
  // post-edge checks at the following negedge (where all inputs are driven).
  task automatic tick();
    logic s_req, s_we, s_ack, s_ev, s_miss, s_resp, s_rst;
    logic [31:0] s_addr, s_wdata, s_rdata, s_ev_addr, s_ev_data, s_miss_addr;
    bit full_before;
    if (auto_ack) begin
      if (o_mem_req === 1'b1) begin
        if (ack_wait >= ack_delay) begin
          i_mem_ack   = 1'b1;
          i_mem_rdata = $urandom;
        end else begin
          i_mem_ack = 1'b0;
          ack_wait++;
        end
      end else begin
        i_mem_ack = 1'b0;
        ack_wait  = 0;
        ack_delay = $urandom_range(0, 3);
      end
    end
    if (o_mem_req === 1'b0) check("idle_bus", {o_mem_addr, o_mem_wdata}, 64'd0);
    if (o_memory_response === 1'b1) begin
      check("resp_expected", 64'(resp_due), 64'd1);
      check("fill_line", 64'(o_memory_line), 64'(exp_line));
      resp_due = 0;
    end
    s_req = o_mem_req;  s_we = o_mem_we;  s_addr = o_mem_addr;  s_wdata = o_mem_wdata;
    s_ack = i_mem_ack;  s_rdata = i_mem_rdata;  s_resp = o_memory_response;
    s_ev = i_evict;  s_ev_addr = i_evict_addr;  s_ev_data = i_evict_data;
    s_miss = i_miss;  s_miss_addr = i_miss_addr;  s_rst = rst;
    @(posedge clk);
    if (!s_rst) begin
      exp_q.delete();
      resp_due = 0;  model_pending = 0;  model_err = 0;  wait_run = 0;
    end else begin
      full_before = (exp_q.size() == WB_DEPTH);
      if (s_req && s_ack) begin
        wait_run = 0;
        if (s_we) begin
          n_wr++;
          check("wb_expected", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) check("wb_addr_data", {s_addr, s_wdata}, exp_q.pop_front());
        end else begin
          n_rd++;
          check("rd_addr", 64'(s_addr), 64'({model_miss_addr[31:6], 6'd0}));
          check("wb_before_fill", 64'(exp_q.size()), 64'd0);
          exp_line = s_rdata;
          resp_due = 1;
        end
      end else if (s_req) begin
        wait_run++;
        if (wait_run == TIMEOUT) begin
          model_err = 1;
          wait_run  = 0;
        end
      end else begin
        wait_run = 0;
      end
      if (s_resp) model_pending = 0;
      else if (s_miss && !model_pending) begin
        model_pending   = 1;
        model_miss_addr = s_miss_addr;
      end
      if (s_ev) begin
        if (full_before) model_err = 1;
        else exp_q.push_back({s_ev_addr[31:6], 6'd0, s_ev_data});
      end
    end
    @(negedge clk);
    check("err", 64'(o_err), 64'(model_err));
    check("wb_full", 64'(o_wb_full), 64'(exp_q.size() == WB_DEPTH));
  endtask

  // Driver tasks
  task automatic do_reset();
    rst = 1'b0;  i_miss = 1'b0;  i_evict = 1'b0;  i_mem_ack = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    n_wr = 0;
    n_rd = 0;
  endtask

  task automatic evict(input logic [31:0] a, input logic [31:0] d);
    i_evict = 1'b1;  i_evict_addr = a;  i_evict_data = d;
    tick();
    i_evict = 1'b0;
  endtask

  task automatic wait_req(input string tag, output bit ok);
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (o_mem_req === 1'b1) begin
        ok = 1;
        break;
      end
      tick();
    end
    check({tag, "_req_seen"}, 64'(ok), 64'd1);
  endtask

  task automatic serve_one(input string tag, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata);
    bit ok;
    wait_req(tag, ok);
    if (ok) begin
      check({tag, "_we"}, 64'(o_mem_we), 64'(we));
      check({tag, "_addr"}, 64'(o_mem_addr), 64'(addr));
      if (we) check({tag, "_wdata"}, 64'(o_mem_wdata), 64'(wdata));
      i_mem_ack = 1'b1;  i_mem_rdata = rdata;
      tick();
      i_mem_ack = 1'b0;  i_mem_rdata = '0;
    end
  endtask

  task automatic wait_resp(input string tag, output int cyc);
    bit seen = 0;
    cyc = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      cyc++;
      if (o_memory_response === 1'b1) begin
        seen = 1;
        break;
      end
    end
    check({tag, "_resp_seen"}, 64'(seen), 64'd1);
    i_miss = 1'b0;
  endtask

  task automatic count_reqs(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (o_mem_req === 1'b1) n++;
    end
  endtask

  initial begin
    int cyc, n, gap, hc, n_ev;
    bit ok;
    logic [31:0] a;
    rst = 1'b0;  i_miss = 1'b0;  i_miss_addr = '0;  i_evict = 1'b0;
    i_evict_addr = '0;  i_evict_data = '0;  i_mem_ack = 1'b0;  i_mem_rdata = '0;
    @(negedge clk);

    // 1: reset held with i_miss high
    i_miss = 1'b1;  i_miss_addr = 32'h0000_ABE7;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_ctrl", 64'({o_mem_req, o_mem_we, o_memory_response, o_wb_full, o_err}), 64'd0);
      check("rst_data", {o_mem_addr, o_mem_wdata}, 64'd0);
      check("rst_line", 64'(o_memory_line), 64'd0);
    end
    rst = 1'b1;
    tick();
    check("t1_req_r0", 64'(o_mem_req), 64'd0);
    tick();
    check("t1_req_r1", 64'(o_mem_req), 64'd0);
    tick();
    check("t1_req_r2", 64'(o_mem_req), 64'd1);
    serve_one("t1", 1'b0, 32'h0000_ABC0, 32'h0, 32'h1234_5678);
    wait_resp("t1", cyc);
    check("t1_line", 64'(o_memory_line), 64'h1234_5678);
    for (int i = 0; i < 3; i++) tick();

    // 2: fill with zero-wait ack, latency and single-cycle response
    i_miss = 1'b1;  i_miss_addr = 32'h0001_2345;
    tick();
    tick();
    tick();
    check("t2_req", 64'(o_mem_req), 64'd1);
    check("t2_we", 64'(o_mem_we), 64'd0);
    check("t2_addr", 64'(o_mem_addr), 64'h0001_2340);
    i_mem_ack = 1'b1;  i_mem_rdata = 32'hDEAD_BEEF;
    tick();
    i_mem_ack = 1'b0;  i_mem_rdata = '0;
    check("t2_req_fall", 64'(o_mem_req), 64'd0);
    check("t2_no_early_resp", 64'(o_memory_response), 64'd0);
    tick();
    check("t2_resp_at_4", 64'(o_memory_response), 64'd1);
    check("t2_line", 64'(o_memory_line), 64'hDEAD_BEEF);
    i_miss = 1'b0;
    tick();
    check("t2_resp_single", 64'(o_memory_response), 64'd0);
    check("t2_line_hold", 64'(o_memory_line), 64'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) tick();

    // 3: evict and miss in the same cycle, writeback goes first
    i_miss = 1'b1;  i_miss_addr = 32'h0000_0100;
    evict(32'h0000_0100, 32'h1111_1111);
    serve_one("t3_wr", 1'b1, 32'h0000_0100, 32'h1111_1111, 32'h0);
    gap = 0;
    for (int i = 0; i < 20; i++) begin
      if (o_mem_req === 1'b1) break;
      gap++;
      tick();
    end
    check("t3_gap_ge1", 64'(gap >= 1), 64'd1);
    serve_one("t3_rd", 1'b0, 32'h0000_0100, 32'h0, 32'h2222_2222);
    wait_resp("t3", cyc);
    check("t3_line", 64'(o_memory_line), 64'h2222_2222);

    // 4: overflow of the writeback FIFO
    do_reset();
    evict(32'h0000_1000, 32'hA0A0_0001);
    check("t4_full_1", 64'(o_wb_full), 64'd0);
    evict(32'h0000_2040, 32'hA0A0_0002);
    check("t4_full_2", 64'(o_wb_full), 64'd1);
    check("t4_err_2", 64'(o_err), 64'd0);
    evict(32'h0000_3080, 32'hA0A0_0003);
    check("t4_err_3", 64'(o_err), 64'd1);
    serve_one("t4_w0", 1'b1, 32'h0000_1000, 32'hA0A0_0001, 32'h0);
    serve_one("t4_w1", 1'b1, 32'h0000_2040, 32'hA0A0_0002, 32'h0);
    count_reqs(12, n);
    check("t4_no_third", 64'(n), 64'd0);
    check("t4_nwr", 64'(n_wr), 64'd2);

    // 5: timeout and reissue
    do_reset();
    i_miss = 1'b1;  i_miss_addr = 32'h0004_5678;
    wait_req("t5_first", ok);
    check("t5_addr1", 64'(o_mem_addr), 64'h0004_5640);
    hc = 0;
    for (int i = 0; i < 20; i++) begin
      if (o_mem_req !== 1'b1) break;
      hc++;
      tick();
    end
    check("t5_high_cycles", 64'(hc), 64'(TIMEOUT));
    check("t5_err", 64'(o_err), 64'd1);
    serve_one("t5_reissue", 1'b0, 32'h0004_5640, 32'h0, 32'h5A5A_A5A5);
    wait_resp("t5", cyc);
    check("t5_line", 64'(o_memory_line), 64'h5A5A_A5A5);
    check("t5_nrd", 64'(n_rd), 64'd1);

    // 6: reset while a writeback is outstanding, late ack ignored
    do_reset();
    evict(32'h0000_5000, 32'h6666_0000);
    wait_req("t6", ok);
    check("t6_we", 64'(o_mem_we), 64'd1);
    rst = 1'b0;
    tick();
    check("t6_req_low", 64'(o_mem_req), 64'd0);
    check("t6_fifo_empty", 64'(o_wb_full), 64'd0);
    rst = 1'b1;  i_mem_ack = 1'b1;
    tick();
    i_mem_ack = 1'b0;
    count_reqs(12, n);
    check("t6_no_writes", 64'(n), 64'd0);
    check("t6_nwr", 64'(n_wr), 64'd0);

    // Random episodes: a few evictions then a miss, memory acks with random delay
    auto_ack = 1;
    for (int ep = 0; ep < 30; ep++) begin
      n_ev = $urandom_range(0, 2);
      for (int k = 0; k < n_ev; k++) begin
        evict($urandom, $urandom);
        for (int g = $urandom_range(0, 2); g > 0; g--) tick();
      end
      a = $urandom;
      i_miss = 1'b1;  i_miss_addr = a;
      wait_resp("rnd", cyc);
      for (int g = 0; g < 3; g++) tick();
      check("rnd_drained", 64'(exp_q.size()), 64'd0);
      check("rnd_line_addr", 64'(model_miss_addr), 64'(a));
    end
    auto_ack = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
